// File: rtl/hist_byte_streamer_if.sv
// Data-memory read port and byte-stream handshake for hist_byte_streamer.
// The master side is the streamer; the slave side is memory plus stream sink.
interface hist_byte_streamer_if #(
  parameter int WORD_W = 128,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 4
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_rd_en, mem_addr, out_data, out_valid,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, out_data, out_valid,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/hist_byte_streamer.sv
// Reads NUM_WORDS histogram words from data memory and streams each one out
// LSB byte first on a valid/ready byte link.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; word counter cleared on start
//   S_FETCH | read strobe with mem_addr = word counter (one cycle)
//   S_LOAD  | capture mem_rdata into the shift register, clear byte count
//   S_SEND  | present shift_reg LSB byte; shift on each accepted beat
//   S_DONE  | one-cycle done pulse, back to idle
module hist_byte_streamer #(
  parameter int WORD_W    = 128,
  parameter int BYTE_W    = 8,
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  hist_byte_streamer_if.master  bus,
  output logic                  busy,
  output logic                  done
);
  localparam int BEATS = WORD_W / BYTE_W;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SEND, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] word_cnt;
  logic [BC_W-1:0]   byte_cnt;
  logic [WORD_W-1:0] shift_reg;
  logic              accept, last_beat, last_word;

  assign accept    = (state == S_SEND) && bus.out_ready;
  assign last_beat = (byte_cnt == BC_W'(BEATS - 1));
  assign last_word = (word_cnt == ADDR_W'(NUM_WORDS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SEND;
      S_SEND:  if (accept && last_beat) state_nxt = last_word ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_FETCH: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = word_cnt;
      end
      S_SEND: begin
        bus.out_valid = 1'b1;
        bus.out_data  = shift_reg[BYTE_W-1:0];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Counters stop at their last value instead of wrapping; LOAD and start reinitialise them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt  <= '0;
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) word_cnt <= '0;
        S_LOAD: begin
          shift_reg <= bus.mem_rdata;
          byte_cnt  <= '0;
        end
        S_SEND: if (accept) begin
          shift_reg <= shift_reg >> BYTE_W;
          if (!last_beat) byte_cnt <= byte_cnt + 1'b1;
          else if (!last_word) word_cnt <= word_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hist_byte_streamer.sv
// Directed bench for hist_byte_streamer: latency, full transfers, backpressure,
// ignored start, mid-transfer reset and a long stall on the final beat.
module tb_hist_byte_streamer;
  localparam int WORD_W    = 128;
  localparam int BYTE_W    = 8;
  localparam int NUM_WORDS = 16;
  localparam int ADDR_W    = 4;
  localparam int TOTAL     = 256;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  always #5 clk = ~clk;

  hist_byte_streamer_if #(.WORD_W(WORD_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W)) bus ();

  hist_byte_streamer #(
    .WORD_W(WORD_W), .BYTE_W(BYTE_W), .NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus.master), .busy(busy), .done(done)
  );

  logic [WORD_W-1:0] mem [NUM_WORDS];

  // One-cycle read latency; junk on the bus whenever no read was issued.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    else               bus.mem_rdata <= {$urandom, $urandom, $urandom, $urandom};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < NUM_WORDS; k++)
      for (int b = 0; b < 16; b++)
        case (mode)
          1:       mem[k][8*b +: 8] = (k == 0) ? 8'(b) : 8'(k);
          2:       mem[k][8*b +: 8] = 8'(k);
          default: mem[k][8*b +: 8] = 8'(k * 16 + b);
        endcase
  endtask

  function automatic logic [7:0] exp_byte(input int idx);
    return mem[idx / 16][8*(idx % 16) +: 8];
  endfunction

  logic [7:0] got [16];
  int r_done_cyc, r_first_rd, r_first_addr, r_first_valid, r_beats, r_bad;
  int r_unstable, r_dones, r_max_addr, r_last_acc;
  logic r_valid_in_done, r_busy_in_done, r_busy_after;
  logic [7:0] r_last_byte;

  // rmode 0: ready held 1; rmode 1: ready toggles. stall_beat holds ready low
  // for 10 cycles on that beat; restart_beat pulses start while that beat is shown.
  task automatic run_xfer(input string tn, input int rmode, input int stall_beat,
                          input int restart_beat, input bit start_in_done);
    int cyc, stall_cnt;
    bit restarted, pvalid, pready, rdy;
    logic [7:0] pdata;
    @(negedge clk);
    start = 1'b1;
    bus.out_ready = 1'b1;
    cyc = 0; stall_cnt = 0; restarted = 0; pvalid = 0; pready = 1; pdata = '0;
    r_done_cyc = -1; r_first_rd = -1; r_first_addr = -1; r_first_valid = -1;
    r_beats = 0; r_bad = 0; r_unstable = 0; r_dones = 0; r_max_addr = 0; r_last_acc = -10;
    r_valid_in_done = 1'b1; r_busy_in_done = 1'b0; r_busy_after = 1'b1; r_last_byte = '0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (bus.mem_rd_en) begin
        if (r_first_rd < 0) begin
          r_first_rd = cyc;
          r_first_addr = int'(bus.mem_addr);
        end
        if (int'(bus.mem_addr) > r_max_addr) r_max_addr = int'(bus.mem_addr);
      end
      if (bus.out_valid && r_first_valid < 0) r_first_valid = cyc;
      if (pvalid && !pready && (!bus.out_valid || bus.out_data != pdata)) r_unstable++;
      if (done) begin
        r_dones++;
        if (r_done_cyc < 0) begin
          r_done_cyc = cyc;
          r_valid_in_done = bus.out_valid;
          r_busy_in_done = busy;
          if (start_in_done) start = 1'b1;
        end
      end
      if (r_done_cyc >= 0 && cyc == r_done_cyc + 1) begin
        r_busy_after = busy;
        break;
      end
      rdy = (rmode == 1) ? (cyc % 2 == 1) : 1'b1;
      if (bus.out_valid && r_beats == stall_beat && stall_cnt < 10) begin
        rdy = 1'b0;
        stall_cnt++;
      end
      bus.out_ready = rdy;
      if (bus.out_valid && r_beats == restart_beat && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (r_beats >= TOTAL || bus.out_data != exp_byte(r_beats)) r_bad++;
        if (r_beats < 16) got[r_beats] = bus.out_data;
        r_last_byte = bus.out_data;
        r_last_acc = cyc;
        r_beats++;
      end
      pvalid = bus.out_valid;
      pready = bus.out_ready;
      pdata = bus.out_data;
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    check_eq({tn, "_first_rd_cyc"}, r_first_rd, 1);
    check_eq({tn, "_first_addr"}, r_first_addr, 0);
    check_eq({tn, "_first_valid_cyc"}, r_first_valid, 3);
    check_eq({tn, "_beats"}, r_beats, TOTAL);
    check_eq({tn, "_bad_bytes"}, r_bad, 0);
    check_eq({tn, "_unstable"}, r_unstable, 0);
    check_eq({tn, "_done_pulses"}, r_dones, 1);
    check_eq({tn, "_max_addr"}, r_max_addr, 15);
    check_eq({tn, "_done_after_last"}, r_done_cyc, r_last_acc + 1);
    check_eq({tn, "_valid_in_done"}, r_valid_in_done, 0);
    check_eq({tn, "_busy_in_done"}, r_busy_in_done, 1);
    check_eq({tn, "_busy_after_done"}, r_busy_after, 0);
  endtask

  task automatic check_quiet(input string tn);
    check_eq({tn, "_rd_en"}, bus.mem_rd_en, 0);
    check_eq({tn, "_addr"}, bus.mem_addr, 0);
    check_eq({tn, "_data"}, bus.out_data, 0);
    check_eq({tn, "_valid"}, bus.out_valid, 0);
    check_eq({tn, "_busy"}, busy, 0);
    check_eq({tn, "_done"}, done, 0);
  endtask

  initial begin
    int cyc, beats;
    bit found, seen;
    bus.out_ready = 1'b1;
    fill(1);
    #2;
    check_quiet("rst");
    @(negedge clk);
    reset = 1'b1;

    // T1: ramp in word 0 comes out 00..0F
    run_xfer("t1", 0, -1, -1, 1'b0);
    for (int b = 0; b < 16; b++) check_eq($sformatf("t1_byte%0d", b), got[b], b);
    check_eq("t1_done_cyc", r_done_cyc, 289);

    // T2: word k filled with byte k
    fill(2);
    run_xfer("t2", 0, -1, -1, 1'b0);
    check_eq("t2_done_cyc", r_done_cyc, 289);
    check_eq("t2_last_byte", r_last_byte, 8'h0F);

    // T3: alternating ready, every beat unique
    fill(3);
    run_xfer("t3", 1, -1, -1, 1'b0);
    check_eq("t3_last_byte", r_last_byte, 8'hFF);

    // T4: start during word 5 and again in the DONE cycle are both ignored
    run_xfer("t4", 0, -1, 5 * 16 + 2, 1'b1);
    check_eq("t4_done_cyc", r_done_cyc, 289);

    // T5: reset while word 7 byte 3 is presented
    @(negedge clk);
    start = 1'b1;
    bus.out_ready = 1'b1;
    cyc = 0; beats = 0; found = 0;
    while (cyc < 1000 && !found) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (bus.out_valid) begin
        if (beats == 7 * 16 + 3) found = 1;
        else beats++;
      end
    end
    check_eq("t5_reached", found, 1);
    check_eq("t5_cyc", cyc, 132);
    reset = 1'b0;
    #1;
    check_quiet("t5_rst");
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || bus.out_valid) seen = 1;
    end
    check_eq("t5_quiet", seen, 0);
    reset = 1'b1;
    run_xfer("t5b", 0, -1, -1, 1'b0);
    check_eq("t5b_done_cyc", r_done_cyc, 289);

    // T6: ten-cycle stall on beat 255
    run_xfer("t6", 0, 255, -1, 1'b0);
    check_eq("t6_done_cyc", r_done_cyc, 299);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
